// File: rtl/add7_arbiter_pkg.sv
// Shared definitions for the two-requester 7-bit adder arbiter.
// Holds the fixed data width and FSM state encodings.
package add7_arbiter_pkg;

    localparam int WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add7_arbiter_rca7.sv
// 7-bit ripple-carry adder shared by both requesters.
// Carry-out is intentionally dropped; results wrap mod 128.
module rca7
    import add7_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s
);

    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/add7_arbiter.sv
// Round-robin arbiter sequencing two requesters onto one shared rca7.
// Define ADD7_ARBITER_SUB_EN to add op0/op1 ports selecting subtraction.
module add7_arbiter
    import add7_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef ADD7_ARBITER_SUB_EN
    input  logic             op0,
    input  logic             op1,
`endif
    input  logic             ack0,
    input  logic             ack1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] s_out
);

    state_t           state;
    logic             prio;
    logic             owner;
    logic             pick;
    logic             owner_ack;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             ci;

`ifdef ADD7_ARBITER_SUB_EN
    logic op_r;

    // Subtraction as a + ~b + 1 through the same adder.
    assign add_b = op_r ? ~b_r : b_r;
    assign ci    = op_r;
`else
    assign add_b = b_r;
    assign ci    = 1'b0;
`endif

    rca7 u_rca7 (
        .a  (a_r),
        .b  (add_b),
        .ci (ci),
        .s  (sum)
    );

    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            req0 && req1:  pick = prio;
            req1 && !req0: pick = 1'b1;
            default:       pick = 1'b0;
        endcase
    end

    assign owner_ack = owner ? ack1 : ack0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            s_out <= '0;
`ifdef ADD7_ARBITER_SUB_EN
            op_r  <= 1'b0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= CALC;
                        owner <= pick;
                        a_r   <= pick ? a1 : a0;
                        b_r   <= pick ? b1 : b0;
`ifdef ADD7_ARBITER_SUB_EN
                        op_r  <= pick ? op1 : op0;
`endif
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                    end
                end
                CALC: begin
                    state <= DONE;
                    s_out <= sum;
                    done0 <= ~owner;
                    done1 <= owner;
                end
                DONE: begin
                    if (owner_ack) begin
                        state <= IDLE;
                        prio  <= ~owner;
                        done0 <= 1'b0;
                        done1 <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add7_arbiter.sv
// Directed self-checking bench for add7_arbiter.
// Define ADD7_ARBITER_SUB_EN to also exercise subtraction.
module tb_add7_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1;
    logic [6:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic       gnt0, gnt1, done0, done1;
    logic [6:0] s_out;
`ifdef ADD7_ARBITER_SUB_EN
    logic       op0, op1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add7_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
`ifdef ADD7_ARBITER_SUB_EN
        .op0     (op0),
        .op1     (op1),
`endif
        .ack0    (ack0),
        .ack1    (ack1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .s_out   (s_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic g0, input logic g1,
                            input logic d0, input logic d1);
        check({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
        check({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
        check({tag, ".done0"}, 32'(done0), 32'(d0));
        check({tag, ".done1"}, 32'(done1), 32'(d1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
`ifdef ADD7_ARBITER_SUB_EN
        op0 = 0; op1 = 0;
`endif
        do_reset();
        chk_outs("reset", 0, 0, 0, 0);
        check("reset.s_out", 32'(s_out), 0);

        // single request, requester 0
        req0 = 1; a0 = 7'd5; b0 = 7'd9;
        tick();
        chk_outs("single.k1", 1, 0, 0, 0);
        req0 = 0;
        tick();
        chk_outs("single.k2", 0, 0, 1, 0);
        check("single.s_out", 32'(s_out), 14);
        tick();
        chk_outs("single.hold", 0, 0, 1, 0);
        ack0 = 1;
        tick();
        ack0 = 0;
        chk_outs("single.ack", 0, 0, 0, 0);

        // wrap, requester 1; stray ack0 must be ignored
        req1 = 1; a1 = 7'd100; b1 = 7'd50;
        tick();
        chk_outs("wrap.k1", 0, 1, 0, 0);
        req1 = 0;
        tick();
        chk_outs("wrap.k2", 0, 0, 0, 1);
        check("wrap.s_out", 32'(s_out), 22);
        ack0 = 1;
        tick();
        ack0 = 0;
        chk_outs("wrap.nonowner_ack", 0, 0, 0, 1);
        check("wrap.s_hold", 32'(s_out), 22);
        ack1 = 1;
        tick();
        ack1 = 0;
        chk_outs("wrap.ack", 0, 0, 0, 0);

        // simultaneous requests after reset
        do_reset();
        req0 = 1; a0 = 7'd1; b0 = 7'd2;
        req1 = 1; a1 = 7'd10; b1 = 7'd20;
        tick();
        chk_outs("dual.g0", 1, 0, 0, 0);
        req0 = 0;
        tick();
        chk_outs("dual.d0", 0, 0, 1, 0);
        check("dual.s0", 32'(s_out), 3);
        ack0 = 1;
        tick();
        ack0 = 0;
        chk_outs("dual.idle", 0, 0, 0, 0);
        tick();
        chk_outs("dual.g1", 0, 1, 0, 0);
        req1 = 0;
        tick();
        chk_outs("dual.d1", 0, 0, 0, 1);
        check("dual.s1", 32'(s_out), 30);
        ack1 = 1;
        tick();
        ack1 = 0;
        chk_outs("dual.end", 0, 0, 0, 0);

        // fairness: both held, immediate acks
        req0 = 1; req1 = 1; ack0 = 1; ack1 = 1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk_outs($sformatf("fair%0d.g", t), (t % 2) == 0, (t % 2) == 1, 0, 0);
            tick();
            chk_outs($sformatf("fair%0d.d", t), 0, 0, (t % 2) == 0, (t % 2) == 1);
            check($sformatf("fair%0d.s", t), 32'(s_out), (t % 2) == 0 ? 3 : 30);
            tick();
        end
        req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
        tick();
        chk_outs("fair.idle", 0, 0, 0, 0);

        // reset while in DONE, owned by requester 1 so prio is 0 afterwards
        req1 = 1; a1 = 7'd4; b1 = 7'd4;
        tick();
        req1 = 0;
        tick();
        chk_outs("rst.pre", 0, 0, 0, 1);
        reset_n = 0;
        tick();
        reset_n = 1;
        chk_outs("rst.post", 0, 0, 0, 0);
        check("rst.s_out", 32'(s_out), 0);
        tick();
        chk_outs("rst.still_idle", 0, 0, 0, 0);
        req0 = 1; a0 = 7'd127; b0 = 7'd1;
        req1 = 1; a1 = 7'd2;   b1 = 7'd3;
        tick();
        chk_outs("rst.dual", 1, 0, 0, 0);
        req0 = 0; req1 = 0;
        tick();
        check("rst.s_wrap", 32'(s_out), 0);
        check("rst.done0", 32'(done0), 1);
        ack0 = 1;
        tick();
        ack0 = 0;

`ifdef ADD7_ARBITER_SUB_EN
        req0 = 1; op0 = 1; a0 = 7'd3; b0 = 7'd5;
        tick();
        req0 = 0; op0 = 0;
        tick();
        check("sub.s_out", 32'(s_out), 126);
        ack0 = 1;
        tick();
        ack0 = 0;
        req0 = 1; op0 = 0; a0 = 7'd3; b0 = 7'd5;
        tick();
        req0 = 0;
        tick();
        check("add.s_out", 32'(s_out), 8);
        ack0 = 1;
        tick();
        ack0 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
